// File: rtl/NXConstants.sv
// Shared mesh message definitions: node ids, commands, load/control payloads
// and the packed node_message_t carried on every mesh link.
package NXConstants;

    localparam int ADDR_ROW_WIDTH      = 4;
    localparam int ADDR_COL_WIDTH      = 4;
    localparam int NODE_PARAM_WIDTH    = 5;
    localparam int NODE_RAM_ADDR_WIDTH = 10;
    localparam int NODE_RAM_DATA_WIDTH = 32;
    localparam int LOAD_DATA_WIDTH     = NODE_RAM_DATA_WIDTH / 2;

    typedef struct packed {
        logic [ADDR_ROW_WIDTH-1:0] row;
        logic [ADDR_COL_WIDTH-1:0] column;
    } node_id_t;

    typedef enum logic [1:0] {
        NODE_COMMAND_LOAD    = 2'd0,
        NODE_COMMAND_SIGNAL  = 2'd1,
        NODE_COMMAND_CONTROL = 2'd2,
        NODE_COMMAND_TRACE   = 2'd3
    } node_command_t;

    typedef enum logic {
        LOWER = 1'b0,
        UPPER = 1'b1
    } node_load_slot_t;

    typedef struct packed {
        logic [ADDR_ROW_WIDTH-1:0] row;
        logic [ADDR_COL_WIDTH-1:0] column;
        node_command_t             command;
    } node_header_t;

    typedef struct packed {
        logic [NODE_RAM_ADDR_WIDTH-1:0] address;
        node_load_slot_t                slot;
        logic [LOAD_DATA_WIDTH-1:0]     data;
    } node_load_t;

    localparam int HEADER_WIDTH  = $bits(node_header_t);
    localparam int PAYLOAD_WIDTH = $bits(node_load_t);
    localparam int MESSAGE_WIDTH = HEADER_WIDTH + PAYLOAD_WIDTH;

    // Control payload is right-aligned in the shared payload field.
    typedef struct packed {
        logic [PAYLOAD_WIDTH-2*NODE_PARAM_WIDTH-1:0] padding;
        logic [NODE_PARAM_WIDTH-1:0]                 num_instr;
        logic [NODE_PARAM_WIDTH-1:0]                 num_output;
    } node_control_t;

    typedef struct packed {
        node_header_t               header;
        logic [PAYLOAD_WIDTH-1:0]   payload;
    } node_message_t;

    function automatic node_message_t build_load_msg(
        input node_id_t                       target,
        input logic [NODE_RAM_ADDR_WIDTH-1:0] address,
        input node_load_slot_t                slot,
        input logic [LOAD_DATA_WIDTH-1:0]     data
    );
        node_message_t msg;
        node_load_t    load;
        load               = '0;
        load.address       = address;
        load.slot          = slot;
        load.data          = data;
        msg                = '0;
        msg.header.row     = target.row;
        msg.header.column  = target.column;
        msg.header.command = NODE_COMMAND_LOAD;
        msg.payload        = load;
        return msg;
    endfunction

    function automatic node_message_t build_ctrl_msg(
        input node_id_t                    target,
        input logic [NODE_PARAM_WIDTH-1:0] num_instr,
        input logic [NODE_PARAM_WIDTH-1:0] num_output
    );
        node_message_t msg;
        node_control_t ctrl;
        ctrl               = '0;
        ctrl.num_instr     = num_instr;
        ctrl.num_output    = num_output;
        msg                = '0;
        msg.header.row     = target.row;
        msg.header.column  = target.column;
        msg.header.command = NODE_COMMAND_CONTROL;
        msg.payload        = ctrl;
        return msg;
    endfunction

endpackage

// File: rtl/nx_node_loader.sv
// Host-side encoder turning a load descriptor plus RAM words into node_load
// half-word messages and a trailing node_control message. Optional feature
// macro: NX_LOADER_STATS_EN adds the saturating o_sent_count statistic.
module nx_node_loader
    import NXConstants::*;
#(
    parameter int RAM_ADDR_W = 10,
    parameter int RAM_DATA_W = 32,
    parameter int CNT_W      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    output logic                        o_idle,
    input  node_id_t                    i_cmd_target,
    input  logic [RAM_ADDR_W-1:0]       i_cmd_base,
    input  logic [RAM_ADDR_W:0]         i_cmd_count,
    input  logic [NODE_PARAM_WIDTH-1:0] i_cmd_num_instr,
    input  logic [NODE_PARAM_WIDTH-1:0] i_cmd_num_output,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [RAM_DATA_W-1:0]       i_word_data,
    input  logic                        i_word_valid,
    output logic                        o_word_ready,
    output logic [MESSAGE_WIDTH-1:0]    o_msg_data,
    output logic                        o_msg_valid,
    input  logic                        i_msg_ready
`ifdef NX_LOADER_STATS_EN
    ,
    output logic [CNT_W-1:0]            o_sent_count
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        SEND_LO   = 3'd2,
        SEND_HI   = 3'd3,
        SEND_CTRL = 3'd4
    } state_t;

    localparam int HALF_W = RAM_DATA_W / 2;

    state_t                      state_q, state_d;
    node_id_t                    target_q, target_d;
    logic [RAM_ADDR_W-1:0]       addr_q, addr_d;
    logic [RAM_ADDR_W:0]         remaining_q, remaining_d;
    logic [NODE_PARAM_WIDTH-1:0] num_instr_q, num_instr_d;
    logic [NODE_PARAM_WIDTH-1:0] num_output_q, num_output_d;
    logic [HALF_W-1:0]           hi_half_q, hi_half_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        msg_valid_q, msg_valid_d;
    logic [MESSAGE_WIDTH-1:0]    msg_data_q, msg_data_d;
    logic                        msg_hs_s;
    logic                        reg_free_s;
    logic                        word_ready_s;

    assign msg_hs_s   = msg_valid_q & i_msg_ready;
    assign reg_free_s = ~msg_valid_q | i_msg_ready;

    // Next-state logic; the output register always runs one message ahead of
    // the state, so the state names the message currently held in it (the HI
    // of a non-final word is held while already waiting for the next word).
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        num_instr_d  = num_instr_q;
        num_output_d = num_output_q;
        hi_half_d    = hi_half_q;
        msg_data_d   = msg_data_q;
        word_ready_s = 1'b0;
        if (msg_hs_s) begin
            msg_valid_d = 1'b0;
        end else begin
            msg_valid_d = msg_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && i_cmd_valid) begin
                    target_d     = i_cmd_target;
                    addr_d       = i_cmd_base;
                    remaining_d  = i_cmd_count;
                    num_instr_d  = i_cmd_num_instr;
                    num_output_d = i_cmd_num_output;
                    if (i_cmd_count != '0) begin
                        state_d = WAIT_WORD;
                    end else begin
                        msg_valid_d = 1'b1;
                        msg_data_d  = build_ctrl_msg(i_cmd_target, i_cmd_num_instr,
                                                     i_cmd_num_output);
                        state_d     = SEND_CTRL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_WORD: begin
                word_ready_s = reg_free_s;
                if (reg_free_s && i_word_valid) begin
                    hi_half_d   = i_word_data[RAM_DATA_W-1:HALF_W];
                    msg_valid_d = 1'b1;
                    msg_data_d  = build_load_msg(target_q,
                                                 NODE_RAM_ADDR_WIDTH'(addr_q), LOWER,
                                                 LOAD_DATA_WIDTH'(i_word_data[HALF_W-1:0]));
                    state_d     = SEND_LO;
                end else begin
                    state_d = WAIT_WORD;
                end
            end
            SEND_LO: begin
                if (msg_hs_s) begin
                    msg_valid_d = 1'b1;
                    msg_data_d  = build_load_msg(target_q,
                                                 NODE_RAM_ADDR_WIDTH'(addr_q), UPPER,
                                                 LOAD_DATA_WIDTH'(hi_half_q));
                    addr_d      = addr_q + RAM_ADDR_W'(1);
                    remaining_d = remaining_q - (RAM_ADDR_W + 1)'(1);
                    if (remaining_q != (RAM_ADDR_W + 1)'(1)) begin
                        state_d = WAIT_WORD;
                    end else begin
                        state_d = SEND_HI;
                    end
                end else begin
                    state_d = SEND_LO;
                end
            end
            SEND_HI: begin
                if (msg_hs_s) begin
                    msg_valid_d = 1'b1;
                    msg_data_d  = build_ctrl_msg(target_q, num_instr_q, num_output_q);
                    state_d     = SEND_CTRL;
                end else begin
                    state_d = SEND_HI;
                end
            end
            SEND_CTRL: begin
                if (msg_hs_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND_CTRL;
                end
            end
            default: begin
                state_d     = IDLE;
                msg_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // State, descriptor and outbound message registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            num_instr_q  <= '0;
            num_output_q <= '0;
            hi_half_q    <= '0;
            cmd_ready_q  <= 1'b0;
            msg_valid_q  <= 1'b0;
            msg_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            num_instr_q  <= num_instr_d;
            num_output_q <= num_output_d;
            hi_half_q    <= hi_half_d;
            cmd_ready_q  <= cmd_ready_d;
            msg_valid_q  <= msg_valid_d;
            msg_data_q   <= msg_data_d;
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_word_ready = word_ready_s;
    assign o_msg_valid  = msg_valid_q;
    assign o_msg_data   = msg_data_q;
    assign o_idle       = (state_q == IDLE) && !msg_valid_q;

`ifdef NX_LOADER_STATS_EN
    logic [CNT_W-1:0] sent_count_q, sent_count_d;

    // Saturating count of outbound handshakes.
    always_comb begin
        if (msg_hs_s && (sent_count_q != {CNT_W{1'b1}})) begin
            sent_count_d = sent_count_q + CNT_W'(1);
        end else begin
            sent_count_d = sent_count_q;
        end
    end

    // Statistics register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sent_count_q <= '0;
        end else begin
            sent_count_q <= sent_count_d;
        end
    end

    assign o_sent_count = sent_count_q;
`else
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = '0;
`endif

endmodule
